// File: rtl/uart_port_arbiter.sv
// Shares one UART receiver/sender pair between the boot Loader and the CPU.
// RX bytes go to the Loader during boot and into an RX FIFO afterwards; the sender is time-shared via a small FSM.
module uart_port_arbiter #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       boot_done,
  input  logic       uart_rx_ready,
  input  logic [7:0] uart_rdata,
  input  logic       uart_tx_busy,
  output logic       uart_tx_start,
  output logic [7:0] uart_sdata,
  output logic       ldr_rx_ready,
  output logic [7:0] ldr_rdata,
  input  logic       ldr_tx_start,
  input  logic [7:0] ldr_sdata,
  output logic       ldr_tx_busy,
  input  logic       cpu_out_valid,
  input  logic [7:0] cpu_out_data,
  output logic       cpu_out_ready,
  output logic       cpu_in_valid,
  output logic [7:0] cpu_in_data,
  input  logic       cpu_in_pop,
  output logic       rx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL_CNT = TX_DEPTH[TX_AW:0];
  localparam logic [RX_AW:0]   RX_FULL_CNT = RX_DEPTH[RX_AW:0];
  localparam logic [TX_AW:0]   TX_CNT_ONE  = 1;
  localparam logic [RX_AW:0]   RX_CNT_ONE  = 1;
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = 1;
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, START, GUARD, DRAIN} tx_state_t;

  tx_state_t state, state_next;

  // ---------------- Loader RX forwarding ----------------
  // NOTE: sequential state always uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      ldr_rx_ready <= 1'b0;
      ldr_rdata    <= '0;
    end else begin
      ldr_rx_ready <= uart_rx_ready & ~boot_done;
      if (uart_rx_ready & ~boot_done) ldr_rdata <= uart_rdata;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_push, rx_pop, rx_full, rx_wr_en;

  assign rx_push  = uart_rx_ready & boot_done;
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_pop   = cpu_in_pop & cpu_in_valid;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign rx_wr_en = rx_push & (~rx_full | rx_pop);

  assign cpu_in_valid = (rx_count != '0);
  assign cpu_in_data  = cpu_in_valid ? rx_mem[rx_rd_ptr] : 8'h00;

  // NOTE: storage arrays carry no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clock) begin
    if (rx_wr_en) rx_mem[rx_wr_ptr] <= uart_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
      if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
      case ({rx_wr_en, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CNT_ONE;
        2'b01:   rx_count <= rx_count - RX_CNT_ONE;
        default: rx_count <= rx_count;
      endcase
      if (rx_push & rx_full & ~rx_pop) rx_overflow <= 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_wr_en, tx_rd_en;

  assign cpu_out_ready = (tx_count != TX_FULL_CNT);
  assign tx_wr_en      = cpu_out_valid & cpu_out_ready;

  always_ff @(posedge clock) begin
    if (tx_wr_en) tx_mem[tx_wr_ptr] <= cpu_out_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_wr_en) tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
      if (tx_rd_en) tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
      case ({tx_wr_en, tx_rd_en})
        2'b10:   tx_count <= tx_count + TX_CNT_ONE;
        2'b01:   tx_count <= tx_count - TX_CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- Loader pending slot ----------------
  logic       slot_full, take_slot;
  logic [7:0] slot_data;

  assign ldr_tx_busy = slot_full | (state != IDLE) | uart_tx_busy;

  // A new request wins over the slot being drained in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_full <= 1'b0;
      slot_data <= '0;
    end else if (ldr_tx_start) begin
      slot_full <= 1'b1;
      slot_data <= ldr_sdata;
    end else if (take_slot) begin
      slot_full <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      uart_sdata <= '0;
    end else begin
      state <= state_next;
      if (take_slot)     uart_sdata <= slot_data;
      else if (tx_rd_en) uart_sdata <= tx_mem[tx_rd_ptr];
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    take_slot     = 1'b0;
    tx_rd_en      = 1'b0;
    uart_tx_start = 1'b0;
    case (state)
      IDLE: begin
        if (!uart_tx_busy) begin
          if (slot_full) begin
            take_slot  = 1'b1;
            state_next = START;
          end else if (tx_count != '0) begin
            tx_rd_en   = 1'b1;
            state_next = START;
          end
        end
      end
      START: begin
        uart_tx_start = 1'b1;
        state_next    = GUARD;
      end
      // Gives the sender a cycle to raise busy before DRAIN looks at it.
      GUARD: state_next = DRAIN;
      DRAIN: if (!uart_tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: boot routing, Loader/CPU send arbitration, RX FIFO limits and reset.
// A small sender model holds busy for a fixed number of cycles after each start pulse.
module tb_uart_port_arbiter;

  localparam int BUSY_CYCLES = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       boot_done;
  logic       uart_rx_ready;
  logic [7:0] uart_rdata;
  logic       uart_tx_busy;
  logic       uart_tx_start;
  logic [7:0] uart_sdata;
  logic       ldr_rx_ready;
  logic [7:0] ldr_rdata;
  logic       ldr_tx_start;
  logic [7:0] ldr_sdata;
  logic       ldr_tx_busy;
  logic       cpu_out_valid;
  logic [7:0] cpu_out_data;
  logic       cpu_out_ready;
  logic       cpu_in_valid;
  logic [7:0] cpu_in_data;
  logic       cpu_in_pop;
  logic       rx_overflow;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  uart_port_arbiter #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .boot_done(boot_done),
    .uart_rx_ready(uart_rx_ready), .uart_rdata(uart_rdata),
    .uart_tx_busy(uart_tx_busy), .uart_tx_start(uart_tx_start), .uart_sdata(uart_sdata),
    .ldr_rx_ready(ldr_rx_ready), .ldr_rdata(ldr_rdata),
    .ldr_tx_start(ldr_tx_start), .ldr_sdata(ldr_sdata), .ldr_tx_busy(ldr_tx_busy),
    .cpu_out_valid(cpu_out_valid), .cpu_out_data(cpu_out_data), .cpu_out_ready(cpu_out_ready),
    .cpu_in_valid(cpu_in_valid), .cpu_in_data(cpu_in_data), .cpu_in_pop(cpu_in_pop),
    .rx_overflow(rx_overflow)
  );

  // Sender model: busy for BUSY_CYCLES after a start pulse, cleared by the shared reset.
  int busy_cnt = 0;
  always @(posedge clock) begin
    if (reset)              busy_cnt <= 0;
    else if (uart_tx_start) busy_cnt <= BUSY_CYCLES;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  // Start-pulse monitor: records sent bytes, spacing and overlap with a busy sender.
  logic [7:0] sent_q[$];
  int cyc = 0;
  int last_start = -100;
  int gap_err = 0;
  int overlap_err = 0;
  always @(negedge clock) begin
    cyc++;
    if (uart_tx_start) begin
      sent_q.push_back(uart_sdata);
      if (cyc - last_start < 4) gap_err++;
      if (uart_tx_busy) overlap_err++;
      last_start = cyc;
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    boot_done = 1'b0; uart_rx_ready = 1'b0; uart_rdata = 8'h00;
    ldr_tx_start = 1'b0; ldr_sdata = 8'h00;
    cpu_out_valid = 1'b0; cpu_out_data = 8'h00; cpu_in_pop = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ldr_tx_busy && n < 100) begin @(negedge clock); n++; end
    total++;
    if (ldr_tx_busy !== 1'b0) $display("FAIL idle_timeout: ldr_tx_busy=%b required 0", ldr_tx_busy);
    else passed++;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (uart_tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", uart_tx_start); else passed++;
    total++; if (uart_sdata !== 8'h00) $display("FAIL rst_sdata: got %h want 00", uart_sdata); else passed++;
    total++; if (ldr_rx_ready !== 1'b0 || ldr_rdata !== 8'h00) $display("FAIL rst_ldr_rx: got %b/%h want 0/00", ldr_rx_ready, ldr_rdata); else passed++;
    total++; if (ldr_tx_busy !== 1'b0) $display("FAIL rst_ldr_busy: got %b want 0", ldr_tx_busy); else passed++;
    total++; if (cpu_out_ready !== 1'b1) $display("FAIL rst_out_ready: got %b want 1", cpu_out_ready); else passed++;
    total++; if (cpu_in_valid !== 1'b0 || cpu_in_data !== 8'h00) $display("FAIL rst_cpu_in: got %b/%h want 0/00", cpu_in_valid, cpu_in_data); else passed++;
    total++; if (rx_overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", rx_overflow); else passed++;
  endtask

  task automatic test_boot_routing();
    logic [7:0] bytes [2];
    bytes[0] = 8'h12; bytes[1] = 8'h34;
    boot_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      uart_rx_ready = 1'b1; uart_rdata = bytes[i];
      @(negedge clock);
      uart_rx_ready = 1'b0; uart_rdata = 8'hFF;
      total++;
      if (ldr_rx_ready !== 1'b1 || ldr_rdata !== bytes[i])
        $display("FAIL boot_fwd_%0d: got rdy=%b data=%h want 1/%h", i, ldr_rx_ready, ldr_rdata, bytes[i]);
      else passed++;
      @(negedge clock);
      total++;
      if (ldr_rx_ready !== 1'b0 || ldr_rdata !== bytes[i])
        $display("FAIL boot_hold_%0d: got rdy=%b data=%h want 0/%h", i, ldr_rx_ready, ldr_rdata, bytes[i]);
      else passed++;
    end
    total++; if (cpu_in_valid !== 1'b0) $display("FAIL boot_no_fifo: cpu_in_valid=%b want 0", cpu_in_valid); else passed++;
  endtask

  task automatic test_loader_send();
    int n;
    int bad;
    ldr_tx_start = 1'b1; ldr_sdata = 8'h99;
    @(negedge clock);
    ldr_tx_start = 1'b0; ldr_sdata = 8'h00;
    total++; if (ldr_tx_busy !== 1'b1) $display("FAIL ldr_busy_slot: got %b want 1", ldr_tx_busy); else passed++;
    n = 0;
    while (!uart_tx_start && n < 5) begin @(negedge clock); n++; end
    total++;
    if (uart_tx_start !== 1'b1 || n != 1) $display("FAIL ldr_start_latency: start=%b after %0d cycles want 1 after 1", uart_tx_start, n);
    else passed++;
    total++; if (uart_sdata !== 8'h99) $display("FAIL ldr_sdata: got %h want 99", uart_sdata); else passed++;
    @(negedge clock);
    total++; if (uart_tx_start !== 1'b0) $display("FAIL ldr_start_width: got %b want 0", uart_tx_start); else passed++;
    bad = 0; n = 0;
    while (uart_tx_busy && n < 50) begin
      if (ldr_tx_busy !== 1'b1 || uart_sdata !== 8'h99) bad++;
      @(negedge clock); n++;
    end
    total++; if (bad != 0 || uart_tx_busy) $display("FAIL ldr_busy_hold: %0d bad cycles, busy=%b want 0/0", bad, uart_tx_busy); else passed++;
    @(negedge clock);
    total++; if (ldr_tx_busy !== 1'b0) $display("FAIL ldr_busy_release: got %b want 0", ldr_tx_busy); else passed++;
  endtask

  task automatic test_priority();
    logic [7:0] want [4];
    int n;
    want[0] = 8'h41; want[1] = 8'hAA; want[2] = 8'h42; want[3] = 8'h43;
    sent_q.delete(); gap_err = 0; overlap_err = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_out_valid = 1'b1; cpu_out_data = 8'h41 + 8'(i);
      @(negedge clock);
    end
    cpu_out_valid = 1'b0;
    n = 0;
    while (sent_q.size() < 1 && n < 20) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    ldr_tx_start = 1'b1; ldr_sdata = 8'hAA;
    @(negedge clock);
    ldr_tx_start = 1'b0;
    n = 0;
    while (sent_q.size() < 4 && n < 300) begin @(negedge clock); n++; end
    total++; if (sent_q.size() != 4) $display("FAIL prio_count: sent %0d bytes want 4", sent_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= sent_q.size()) $display("FAIL prio_order_%0d: missing byte want %h", i, want[i]);
      else if (sent_q[i] !== want[i]) $display("FAIL prio_order_%0d: got %h want %h", i, sent_q[i], want[i]);
      else passed++;
    end
    total++; if (gap_err != 0 || overlap_err != 0) $display("FAIL prio_spacing: gap_err=%0d overlap_err=%0d want 0/0", gap_err, overlap_err); else passed++;
    wait_idle();
  endtask

  task automatic test_rx_overflow();
    apply_reset();
    boot_done = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      uart_rx_ready = 1'b1; uart_rdata = 8'(i);
      @(negedge clock);
    end
    uart_rx_ready = 1'b0;
    @(negedge clock);
    total++; if (rx_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", rx_overflow); else passed++;
    total++; if (ldr_rx_ready !== 1'b0) $display("FAIL ovf_no_ldr: got %b want 0", ldr_rx_ready); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (cpu_in_valid !== 1'b1 || cpu_in_data !== 8'(i)) $display("FAIL ovf_pop_%0d: got v=%b %h want 1/%h", i, cpu_in_valid, cpu_in_data, 8'(i));
      else passed++;
      cpu_in_pop = 1'b1;
      @(negedge clock);
      cpu_in_pop = 1'b0;
    end
    total++; if (cpu_in_valid !== 1'b0) $display("FAIL ovf_lost_byte: cpu_in_valid=%b want 0", cpu_in_valid); else passed++;
    cpu_in_pop = 1'b1;
    @(negedge clock);
    cpu_in_pop = 1'b0;
    uart_rx_ready = 1'b1; uart_rdata = 8'h77;
    @(negedge clock);
    uart_rx_ready = 1'b0;
    total++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 8'h77 || rx_overflow !== 1'b1)
      $display("FAIL empty_pop_ignored: got v=%b %h ovf=%b want 1/77/1", cpu_in_valid, cpu_in_data, rx_overflow);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    apply_reset();
    boot_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_rx_ready = 1'b1; uart_rdata = 8'h60 + 8'(i);
      @(negedge clock);
    end
    uart_rdata = 8'h55; cpu_in_pop = 1'b1;
    @(negedge clock);
    uart_rx_ready = 1'b0; cpu_in_pop = 1'b0;
    total++; if (rx_overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b want 0", rx_overflow); else passed++;
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'h61 + 8'(i) : 8'h55;
      total++;
      if (cpu_in_valid !== 1'b1 || cpu_in_data !== want) $display("FAIL full_pp_pop_%0d: got v=%b %h want 1/%h", i, cpu_in_valid, cpu_in_data, want);
      else passed++;
      cpu_in_pop = 1'b1;
      @(negedge clock);
      cpu_in_pop = 1'b0;
    end
    total++; if (cpu_in_valid !== 1'b0) $display("FAIL full_pp_count: cpu_in_valid=%b want 0 after 16 pops", cpu_in_valid); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int n;
    int sent_before;
    sent_q.delete();
    for (int i = 0; i < 6; i++) begin
      cpu_out_valid = 1'b1; cpu_out_data = 8'hB0 + 8'(i);
      @(negedge clock);
    end
    cpu_out_valid = 1'b0;
    n = 0;
    while (sent_q.size() < 1 && n < 20) begin @(negedge clock); n++; end
    repeat (3) @(negedge clock);
    total++; if (ldr_tx_busy !== 1'b1 || uart_tx_busy !== 1'b1) $display("FAIL midop_inflight: ldr_busy=%b tx_busy=%b want 1/1", ldr_tx_busy, uart_tx_busy); else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++;
    if (uart_tx_start !== 1'b0 || uart_sdata !== 8'h00 || ldr_tx_busy !== 1'b0 || ldr_rx_ready !== 1'b0 ||
        ldr_rdata !== 8'h00 || cpu_out_ready !== 1'b1 || cpu_in_valid !== 1'b0 || rx_overflow !== 1'b0)
      $display("FAIL midop_reset_outputs: start=%b sdata=%h lbusy=%b lrdy=%b lrdata=%h ordy=%b ivld=%b ovf=%b want 0/00/0/0/00/1/0/0",
               uart_tx_start, uart_sdata, ldr_tx_busy, ldr_rx_ready, ldr_rdata, cpu_out_ready, cpu_in_valid, rx_overflow);
    else passed++;
    sent_before = sent_q.size();
    repeat (30) @(negedge clock);
    total++; if (sent_q.size() != sent_before) $display("FAIL midop_no_start: %0d starts after reset want 0", sent_q.size() - sent_before); else passed++;
    total++; if (cpu_out_ready !== 1'b1 || ldr_tx_busy !== 1'b0) $display("FAIL midop_idle: ordy=%b lbusy=%b want 1/0", cpu_out_ready, ldr_tx_busy); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    boot_done = 1'b0; uart_rx_ready = 1'b0; uart_rdata = 8'h00;
    ldr_tx_start = 1'b0; ldr_sdata = 8'h00;
    cpu_out_valid = 1'b0; cpu_out_data = 8'h00; cpu_in_pop = 1'b0;
    test_reset();
    test_boot_routing();
    test_loader_send();
    test_priority();
    test_rx_overflow();
    test_full_push_pop();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_port_arbiter.md
Name: uart_port_arbiter

Overview:
- Shares the single UART receiver/sender pair between the boot Loader and the running CPU's in/out instructions.
- During boot, routes received bytes to the Loader; afterwards, buffers them in an RX FIFO for the CPU.
- Multiplexes Loader handshake bytes and CPU output bytes (buffered in a TX FIFO) onto the one sender, one byte in flight at a time.
- Sits in the top level between the UART cores, the Loader and the core.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, at least 2.
RX_DEPTH, 16, RX FIFO entries; power of two, at least 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
boot_done  input  1  level; 0 routes RX to Loader, 1 routes RX to CPU FIFO
uart_rx_ready  input  1  one-cycle pulse, byte received
uart_rdata  input  8  received byte, valid with uart_rx_ready
uart_tx_busy  input  1  sender busy
uart_tx_start  output  1  one-cycle start pulse to sender
uart_sdata  output  8  byte to send, stable from start until busy falls
ldr_rx_ready  output  1  one-cycle pulse to Loader
ldr_rdata  output  8  byte to Loader
ldr_tx_start  input  1  one-cycle request from Loader
ldr_sdata  input  8  Loader byte, valid with ldr_tx_start
ldr_tx_busy  output  1  busy indication to Loader
cpu_out_valid  input  1  CPU output byte valid
cpu_out_data  input  8  CPU output byte
cpu_out_ready  output  1  TX FIFO not full
cpu_in_valid  output  1  RX FIFO not empty
cpu_in_data  output  8  RX FIFO head (show-ahead)
cpu_in_pop  input  1  consume head
rx_overflow  output  1  sticky; RX byte dropped

Behaviour:
- Reset: clock and reset as already decided (reset reset, synchronous, active-high; clock clock). All outputs are 0 out of reset, except cpu_out_ready=1. Both FIFOs empty, Loader pending slot empty, TX FSM in IDLE, rx_overflow=0. Reset mid-transfer abandons the byte; any queued FIFO data is lost.
- RX routing: decided by boot_done sampled in the same cycle as uart_rx_ready.
  - boot_done=0: ldr_rx_ready pulses exactly 1 cycle after uart_rx_ready, with ldr_rdata registered from uart_rdata. ldr_rdata holds its value until the next forwarded byte.
  - boot_done=1: byte is pushed into the RX FIFO; no ldr_rx_ready pulse.
- RX FIFO:
  - cpu_in_valid and cpu_in_data reflect the stored head; a pushed byte is visible the cycle after the push.
  - cpu_in_pop with cpu_in_valid=1 removes the head at the clock edge; pop while empty is ignored.
  - Push when full with no pop in the same cycle: byte dropped, rx_overflow set and held until reset.
  - Push and pop in the same cycle: both take effect, count unchanged, even when full. Pointers wrap modulo RX_DEPTH.
- TX FIFO:
  - Write occurs when cpu_out_valid & cpu_out_ready.
  - cpu_out_ready = ~full (registered count); simultaneous write and TX FSM read are both allowed.
- Loader pending slot:
  - ldr_tx_start latches ldr_sdata into a 1-entry slot.
  - ldr_tx_busy = slot_full | (FSM != IDLE) | uart_tx_busy.
  - A request while ldr_tx_busy=1 is a protocol violation and overwrites the slot.
- TX FSM states: IDLE, START, GUARD, DRAIN.
  - IDLE -> START when ~uart_tx_busy and (slot_full or TX FIFO non-empty). Loader slot has strict priority over the FIFO. In this transition, latch the chosen byte into uart_sdata and free its source.
  - START: uart_tx_start=1 for exactly this one cycle; -> GUARD.
  - GUARD: one cycle, covering the sender's busy-rise latency; -> DRAIN.
  - DRAIN: wait until uart_tx_busy=0, then -> IDLE.
  - Minimum 4 cycles between consecutive start pulses. Exactly one byte in flight.
- Loader may request a send while boot_done=1; the FIFO source remains usable while boot_done=0. Both are arbitrated identically.

Test Plan:
- Boot routing: boot_done=0; uart_rx_ready pulses with 0x12, 0x34 -> ldr_rx_ready pulses 1 cycle after each with ldr_rdata 0x12 then 0x34; cpu_in_valid stays 0.
- Loader send: ldr_tx_start with 0x99; sender model holds busy 10 cycles -> uart_tx_start one cycle later with uart_sdata=0x99; ldr_tx_busy=1 until busy falls.
- Priority: 3 bytes (0x41, 0x42, 0x43) queued in TX FIFO plus Loader 0xAA requested while the first FIFO byte is in flight -> send order 0x41, 0xAA, 0x42, 0x43; no overlapping start pulses.
- RX overflow: boot_done=1; push 17 bytes 0x00..0x10 with no pops (RX_DEPTH=16) -> rx_overflow=1; popping yields 0x00..0x0F; 0x10 is lost.
- Full-FIFO push+pop: RX FIFO full; new byte 0x55 arrives in the same cycle as cpu_in_pop -> no overflow, count stays 16, 0x55 read last.
- Reset mid-op: assert reset during DRAIN with 5 bytes queued -> next cycle all outputs at reset values, cpu_out_ready=1, no further uart_tx_start.
